// File: rtl/window_gen_pkg.sv
// Shared pixel-format constants and 3x3 window slot layout for the window generator.
package window_gen_pkg;

  localparam int PIXEL_SIZE = 8;
  localparam int PIXEL_W    = PIXEL_SIZE;

  localparam int WIN_DIM   = 3;
  localparam int WIN_SLOTS = WIN_DIM * WIN_DIM;

  // Slots that receive the freshly read column: r0 from LB, r1 from LA, r2 from the input.
  localparam int SLOT_NEW_TOP = 2;
  localparam int SLOT_NEW_MID = 5;
  localparam int SLOT_NEW_BOT = 8;

  function automatic int slot_idx(input int r, input int c);
    return WIN_DIM * r + c;
  endfunction

endpackage

// File: rtl/line_ram.sv
// One image line of pixels: asynchronous read, synchronous write, no reset.
module line_ram
  import window_gen_pkg::*;
#(
  parameter int DEPTH = 640,
  parameter int DW    = PIXEL_W,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem_q [DEPTH];

  assign rdata = mem_q[addr];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
  end

endmodule

// File: rtl/window_gen.sv
// Raster-scan 3x3 neighbourhood generator built from two line buffers and a
// 3x3 shift window; emits one window per interior pixel.
module window_gen
  import window_gen_pkg::*;
#(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           en,
  input  logic [PIXEL_W-1:0]             data,
  output logic                           out_valid,
  output logic [WIN_SLOTS*PIXEL_W-1:0]   out_window,
  output logic [$clog2(WIDTH)-1:0]       out_x,
  output logic [$clog2(HEIGHT)-1:0]      out_y
);

  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);
  localparam logic [XW-1:0] COL_LAST = XW'(WIDTH - 1);
  localparam logic [YW-1:0] ROW_LAST = YW'(HEIGHT - 1);

  logic [XW-1:0]      col_q, col_d;
  logic [YW-1:0]      row_q, row_d;
  logic [PIXEL_W-1:0] la_rd, lb_rd;
  logic [PIXEL_W-1:0] win_q [WIN_SLOTS];
  logic [PIXEL_W-1:0] win_d [WIN_SLOTS];
  logic               valid_q, valid_d;
  logic [XW-1:0]      x_q, x_d;
  logic [YW-1:0]      y_q, y_d;

  // LB is fed from LA's read port, so the two buffers form a two-line delay.
  line_ram #(.DEPTH(WIDTH), .DW(PIXEL_W), .AW(XW)) u_la (
    .clk   (clk),
    .we    (en),
    .addr  (col_q),
    .wdata (data),
    .rdata (la_rd)
  );

  line_ram #(.DEPTH(WIDTH), .DW(PIXEL_W), .AW(XW)) u_lb (
    .clk   (clk),
    .we    (en),
    .addr  (col_q),
    .wdata (la_rd),
    .rdata (lb_rd)
  );

  always_comb begin
    col_d   = col_q;
    row_d   = row_q;
    win_d   = win_q;
    valid_d = 1'b0;
    x_d     = x_q;
    y_d     = y_q;
    if (en) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + YW'(1);
      end else begin
        col_d = col_q + XW'(1);
      end
      for (int r = 0; r < WIN_DIM; r++) begin
        win_d[slot_idx(r, 0)] = win_q[slot_idx(r, 1)];
        win_d[slot_idx(r, 1)] = win_q[slot_idx(r, 2)];
      end
      win_d[SLOT_NEW_TOP] = lb_rd;
      win_d[SLOT_NEW_MID] = la_rd;
      win_d[SLOT_NEW_BOT] = data;
      // Only interior pixels complete a window; edge windows would mix rows or frames.
      if ((row_q >= YW'(2)) && (col_q >= XW'(2))) begin
        valid_d = 1'b1;
        x_d     = col_q - XW'(1);
        y_d     = row_q - YW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col_q   <= '0;
      row_q   <= '0;
      valid_q <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      for (int k = 0; k < WIN_SLOTS; k++) begin
        win_q[k] <= '0;
      end
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      valid_q <= valid_d;
      x_q     <= x_d;
      y_q     <= y_d;
      win_q   <= win_d;
    end
  end

  always_comb begin
    out_window = '0;
    for (int k = 0; k < WIN_SLOTS; k++) begin
      out_window[PIXEL_W*k +: PIXEL_W] = win_q[k];
    end
  end

  assign out_valid = valid_q;
  assign out_x     = x_q;
  assign out_y     = y_q;

endmodule

// File: tb/tb_window_gen.sv
// Directed bench for window_gen on a 4x4 image: frames, enable gaps, back-to-back
// frames, mid-frame reset and saturated pixel values.
module tb_window_gen;
  import window_gen_pkg::*;

  localparam int W  = 4;
  localparam int H  = 4;
  localparam int WW = WIN_SLOTS * PIXEL_W;

  logic              clk;
  logic              reset;
  logic              en;
  logic [PIXEL_W-1:0] data;
  logic              out_valid;
  logic [WW-1:0]     out_window;
  logic [1:0]        out_x;
  logic [1:0]        out_y;

  int pass_cnt;
  int total_cnt;
  int fail_cnt;
  int pulses;

  window_gen #(.WIDTH(W), .HEIGHT(H)) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .data       (data),
    .out_valid  (out_valid),
    .out_window (out_window),
    .out_x      (out_x),
    .out_y      (out_y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [WW-1:0] pack9(input int s0, input int s1, input int s2,
                                          input int s3, input int s4, input int s5,
                                          input int s6, input int s7, input int s8);
    logic [WW-1:0] w;
    w = '0;
    w[0*8 +: 8] = 8'(s0); w[1*8 +: 8] = 8'(s1); w[2*8 +: 8] = 8'(s2);
    w[3*8 +: 8] = 8'(s3); w[4*8 +: 8] = 8'(s4); w[5*8 +: 8] = 8'(s5);
    w[6*8 +: 8] = 8'(s6); w[7*8 +: 8] = 8'(s7); w[8*8 +: 8] = 8'(s8);
    return w;
  endfunction

  function automatic int pix(input int base, input bit ff, input int r, input int c);
    return ff ? 255 : base + W * r + c;
  endfunction

  // Window centred one row up and one column left of the pixel just accepted at (r,c).
  function automatic logic [WW-1:0] exp_win(input int base, input bit ff, input int r, input int c);
    logic [WW-1:0] w;
    w = '0;
    for (int rr = 0; rr < 3; rr++) begin
      for (int cc = 0; cc < 3; cc++) begin
        w[8*(3*rr+cc) +: 8] = 8'(pix(base, ff, r - 2 + rr, c - 2 + cc));
      end
    end
    return w;
  endfunction

  task automatic idle_cycle();
    en = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Streams one frame; gap_after inserts 3 idle cycles, reset_after aborts the frame with a reset.
  task automatic run_frame(input int base, input bit ff, input int gap_after, input int reset_after);
    int r;
    int c;
    bit ev;
    pulses = 0;
    for (int i = 0; i < W * H; i++) begin
      r = i / W;
      c = i % W;
      data = 8'(pix(base, ff, r, c));
      en = 1'b1;
      @(posedge clk);
      #1;
      ev = (r >= 2) && (c >= 2);
      check($sformatf("valid_b%0d_p%0d", base, i), WW'(out_valid), WW'(ev));
      if (out_valid === 1'b1) pulses++;
      if (ev) begin
        check($sformatf("win_b%0d_p%0d", base, i), out_window, exp_win(base, ff, r, c));
        check($sformatf("x_b%0d_p%0d", base, i), WW'(out_x), WW'(c - 1));
        check($sformatf("y_b%0d_p%0d", base, i), WW'(out_y), WW'(r - 1));
      end
      if (!ff && base == 0 && i == 10)
        check("first_win_const", out_window, pack9(0, 1, 2, 4, 5, 6, 8, 9, 10));
      if (!ff && base == 0 && i == 15)
        check("last_win_const", out_window, pack9(5, 6, 7, 9, 10, 11, 13, 14, 15));
      if (!ff && base == 100 && i == 10)
        check("f2_first_win_const", out_window, pack9(100, 101, 102, 104, 105, 106, 108, 109, 110));
      if (i == gap_after) begin
        for (int g = 0; g < 3; g++) begin
          idle_cycle();
          check($sformatf("gap_valid_%0d", g), WW'(out_valid), '0);
          if (ev) begin
            check($sformatf("gap_win_%0d", g), out_window, exp_win(base, ff, r, c));
            check($sformatf("gap_xy_%0d", g), WW'({out_y, out_x}), WW'({2'(r - 1), 2'(c - 1)}));
          end else begin
            check($sformatf("gap_win_hi_%0d", g), out_window[WW-1:24], exp_win(base, ff, r, c) >> 24);
          end
        end
      end
      if (i == reset_after) begin
        en = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check("rst_valid", WW'(out_valid), '0);
        check("rst_window", out_window, '0);
        check("rst_xy", WW'({out_y, out_x}), '0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        return;
      end
    end
    check($sformatf("pulses_b%0d", base), WW'(pulses), WW'((W - 2) * (H - 2)));
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    fail_cnt  = 0;
    reset = 1'b0;
    en    = 1'b0;
    data  = '0;
    #3;
    check("reset_valid", WW'(out_valid), '0);
    check("reset_window", out_window, '0);
    check("reset_x", WW'(out_x), '0);
    check("reset_y", WW'(out_y), '0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Frame with an idle gap after pixel 6 and another after the first valid window.
    run_frame(0, 1'b0, 6, -1);
    run_frame(0, 1'b0, 10, -1);
    // Back-to-back frame with offset data.
    run_frame(100, 1'b0, -1, -1);
    // Abort mid-frame, then restart from (0,0).
    run_frame(0, 1'b0, -1, 11);
    run_frame(0, 1'b0, -1, -1);
    // Saturated pixels pass unmodified.
    run_frame(0, 1'b1, -1, -1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/window_gen.md
WINDOW_GEN -- requirements
Module: window_gen

Interface
REQ-001 SHALL have parameter WIDTH, default 640: image width in pixels, at least 3.
REQ-002 SHALL have parameter HEIGHT, default 480: image height in pixels, at least 3.
REQ-003 SHALL have input clk, 1 bit: single clock; all state changes on the rising edge.
REQ-004 SHALL have input reset, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have input en, 1 bit: a pixel is accepted on each rising edge where en=1.
REQ-006 SHALL have input data, PIXEL_W bits: grayscale pixel, raster order, row-major, top-left first.
REQ-007 SHALL have output out_valid, 1 bit: out_window, out_x and out_y hold a complete window.
REQ-008 SHALL have output out_window, 9*PIXEL_W bits: 3x3 neighbourhood; slot k=3*r+c at [PIXEL_W*k +: PIXEL_W]; r=0 is the oldest row, c=0 the oldest column.
REQ-009 SHALL have output out_x, $clog2(WIDTH) bits: column of the window centre.
REQ-010 SHALL have output out_y, $clog2(HEIGHT) bits: row of the window centre.

Function
REQ-011 SHALL keep column counter col (0..WIDTH-1) and row counter row (0..HEIGHT-1), both naming the position of the next accepted pixel.
REQ-012 On acceptance: col increments; at WIDTH-1, col wraps to 0 and row increments; at (WIDTH-1, HEIGHT-1), row also wraps to 0, with no idle cycle between frames.
REQ-013 SHALL hold two line buffers of WIDTH entries: LA holds row-1, LB holds row-2.
REQ-014 On acceptance, SHALL read LB[col] and LA[col] before writing, then write LB[col] <= LA[col] and LA[col] <= data (read-before-write, same edge).
REQ-015 On acceptance, SHALL shift the window left one column: c0<=c1, c1<=c2; new c2 is {r0: LB[col], r1: LA[col], r2: data}.
REQ-016 out_valid SHALL be registered: 1 after an accepting edge with row>=2 and col>=2, else 0.
REQ-017 Latency: the window for the pixel accepted at edge N is visible immediately after edge N; slot 8 equals that pixel.
REQ-018 On a valid output, out_x SHALL equal col-1 and out_y SHALL equal row-1 of the pixel just accepted.
REQ-019 With en=0: counters, window, buffers, out_x and out_y hold; out_valid=0 from the next edge.
REQ-020 Windows straddling a row boundary (col<2) or the frame top (row<2) SHALL never assert out_valid.
REQ-021 Exactly (WIDTH-2)*(HEIGHT-2) out_valid pulses SHALL occur per frame.
REQ-022 Pixel values SHALL pass unmodified, with no arithmetic or saturation.

Reset
REQ-023 While reset=0, regardless of clk: col=0, row=0, out_valid=0, out_window=0, out_x=0, out_y=0.
REQ-024 Line buffer contents SHALL NOT be reset; stale contents are masked by REQ-020.
REQ-025 After reset mid-frame, the next accepted pixel SHALL be treated as (0,0) of a new frame.

Structure
REQ-026 PIXEL_W (8) and the window slot-index constants SHALL live in the shared global package/header alongside PIXEL_SIZE.
REQ-027 One sub-module, line_ram, SHALL implement each line buffer: WIDTH x PIXEL_W register array, asynchronous read, synchronous write, no reset; instantiated twice.

Verification (WIDTH=4, HEIGHT=4, data = pixel index 0..15, en=1 continuously)
REQ-028 Full frame -> first out_valid after pixel 10 is accepted; out_window slots 0..8 = {0,1,2,4,5,6,8,9,10}; out_x=1, out_y=1.
REQ-029 Full frame -> exactly 4 out_valid pulses, centres (1,1),(2,1),(1,2),(2,2); last window = {5,6,7,9,10,11,13,14,15}.
REQ-030 en=0 for 3 cycles after pixel 6 -> out_valid=0 throughout, outputs held; resumed stream produces windows identical to REQ-028/029.
REQ-031 Two back-to-back frames, second frame data = index+100 -> no out_valid during the second frame's rows 0-1; first window = {100,101,102,104,105,106,108,109,110}.
REQ-032 reset pulsed low asynchronously after pixel 11 -> out_valid=0 and all outputs 0 immediately; restarted frame matches REQ-028.
REQ-033 All pixels set to 255 -> every valid window has all nine slots equal to 255.
